// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, optional even/odd parity, mid-bit sampling.
// Delivers each word with parity and framing flags; a line break yields a single word.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_x16,
    input  logic                 i_rx,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    state_t                 state_reg, state_next;
    logic [3:0]             os_cnt_reg, os_cnt_next;
    logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   par_en_reg, par_en_next;
    logic                   par_odd_reg, par_odd_next;
    logic                   perr_reg, perr_next;
    // Cleared when a frame ends on a low stop bit, so a held break yields only one word.
    logic                   armed_reg, armed_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   valid_reg, valid_next;
    logic                   perr_out_reg, perr_out_next;
    logic                   ferr_reg, ferr_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg[0] <= i_rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign rxs = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_en_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
            perr_reg     <= 1'b0;
            armed_reg    <= 1'b1;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            os_cnt_reg   <= os_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            par_en_reg   <= par_en_next;
            par_odd_reg  <= par_odd_next;
            perr_reg     <= perr_next;
            armed_reg    <= armed_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            perr_out_reg <= perr_out_next;
            ferr_reg     <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        os_cnt_next   = os_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        par_en_next   = par_en_reg;
        par_odd_next  = par_odd_reg;
        perr_next     = perr_reg;
        armed_next    = armed_reg;
        data_next     = data_reg;
        valid_next    = 1'b0;
        perr_out_next = perr_out_reg;
        ferr_next     = ferr_reg;

        case (state_reg)
            IDLE: begin
                if (rxs) begin
                    armed_next = 1'b1;
                end
                if (i_baud_x16 && !rxs && armed_reg) begin
                    state_next  = START;
                    os_cnt_next = '0;
                end
            end
            START: begin
                if (i_baud_x16) begin
                    if (os_cnt_reg == 4'd7) begin
                        if (rxs) begin
                            state_next = IDLE;
                        end else begin
                            state_next   = DATA;
                            os_cnt_next  = '0;
                            bit_cnt_next = '0;
                            par_en_next  = i_parity_en;
                            par_odd_next = i_parity_odd;
                            perr_next    = 1'b0;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_baud_x16) begin
                    os_cnt_next = os_cnt_reg + 4'd1;
                    if (os_cnt_reg == 4'd15) begin
                        shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = par_en_reg ? PARITY : STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (i_baud_x16) begin
                    os_cnt_next = os_cnt_reg + 4'd1;
                    if (os_cnt_reg == 4'd15) begin
                        perr_next  = ((^shift_reg) ^ rxs) != par_odd_reg;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (i_baud_x16) begin
                    os_cnt_next = os_cnt_reg + 4'd1;
                    if (os_cnt_reg == 4'd15) begin
                        state_next    = IDLE;
                        valid_next    = 1'b1;
                        data_next     = shift_reg;
                        perr_out_next = perr_reg;
                        ferr_next     = !rxs;
                        if (!rxs) begin
                            armed_next = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data       = data_reg;
    assign o_valid      = valid_reg;
    assign o_parity_err = perr_out_reg;
    assign o_frame_err  = ferr_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, expected words queued at send
// time and matched against each o_valid pulse.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_x16 = 1'b0;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int div = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_baud_x16  (baud_x16),
        .i_rx        (rx),
        .i_parity_en (parity_en),
        .i_parity_odd(parity_odd),
        .o_data      (data),
        .o_valid     (valid),
        .o_parity_err(perr),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Oversample strobe: one clock high every four clocks.
    always @(negedge clk) begin
        if (div == 3) begin
            baud_x16 = 1'b1;
            div = 0;
        end else begin
            baud_x16 = 1'b0;
            div++;
        end
    end

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid data=%h perr=%b ferr=%b required=no_valid", data, perr, ferr);
            end else begin
                mon_e = sb.pop_front();
                if ({data, perr, ferr} !== {mon_e.data, mon_e.perr, mon_e.ferr}) begin
                    failures++;
                    $display("FAIL word data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                             data, perr, ferr, mon_e.data, mon_e.perr, mon_e.ferr);
                end else begin
                    $display("word data=%h perr=%b ferr=%b ok", data, perr, ferr);
                end
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog cycles=100000 required=finish_earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int n);
        exp_t e;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(pbit);
        e.data = d;
        e.perr = parity_en && (parity_odd ? (ones % 2 == 0) : (ones % 2 == 1));
        e.ferr = ~stop;
        sb.push_back(e);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        if (parity_en) drive_bit(pbit, n);
        drive_bit(stop, n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({valid, perr, ferr, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags valid/perr/ferr/busy=%b required=0000", {valid, perr, ferr, busy});
        end
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data data=%h required=00", data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1;
        parity_en = 1'b0;
        drive_bit(1'b1, 2 * BIT_CLKS);
        send_frame(8'hA5, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL 8n1_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_busy busy=%b required=0", busy);
        end
    endtask

    task automatic test_parity;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h37, 1'b1, 1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS / 2);
        send_frame(8'h37, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL parity_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
        parity_en = 1'b0;
    endtask

    task automatic test_frame_err;
        exp_t e;
        send_frame(8'h5A, 1'b0, 1'b0, BIT_CLKS);
        drive_bit(1'b1, 2 * BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL frame_err_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
        e.data = 8'h00;
        e.perr = 1'b0;
        e.ferr = 1'b1;
        sb.push_back(e);
        drive_bit(1'b0, 20 * BIT_CLKS);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL break_busy busy=%b required=0", busy);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL break_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
        drive_bit(1'b1, 2 * BIT_CLKS);
    endtask

    task automatic test_glitch;
        drive_bit(1'b0, 20);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high busy=%b required=1", busy);
        end
        drive_bit(1'b1, 100);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_low busy=%b required=0", busy);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b0, 1'b1, BIT_CLKS);
        send_frame(8'hFF, 1'b0, 1'b1, BIT_CLKS);
        send_frame(8'h81, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL back_to_back_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        d = 8'h3C;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[3], BIT_CLKS / 2);
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, perr, ferr, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_flags valid/perr/ferr/busy=%b required=0000", {valid, perr, ferr, busy});
        end
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL midreset_data data=%h required=00", data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 2 * BIT_CLKS);
        send_frame(8'h3C, 1'b0, 1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_skew;
        send_frame(8'h96, 1'b0, 1'b1, BIT_CLKS + 2);
        drive_bit(1'b1, BIT_CLKS);
        send_frame(8'h96, 1'b0, 1'b1, BIT_CLKS - 2);
        drive_bit(1'b1, BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL skew_drained pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_skew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
